// File: rtl/reaction_timer_unit.sv
// Reaction-game timing responder: random and fixed waits on a shared 1 ms
// prescaler, plus a saturating millisecond reaction counter for the display.
module reaction_timer_chan #(
  parameter int CW = 13
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req,
  input  logic          wtick,
  input  logic [CW-1:0] load_val,
  output logic          rise,
  output logic          done
);
  logic          prev, armed;
  logic [CW-1:0] cnt;

  assign rise = req & ~prev;
  assign done = req & armed & (cnt == '0);

  // prev resets high so a request held across reset release is not a new edge
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev  <= 1'b1;
      armed <= 1'b0;
      cnt   <= '0;
    end else begin
      prev <= req;
      if (rise) begin
        cnt   <= load_val;
        armed <= 1'b1;
      end else begin
        if (!req) armed <= 1'b0;
        if (req && cnt != '0 && wtick) cnt <= cnt - 1'b1;
      end
    end
  end
endmodule

module reaction_timer_unit #(
  parameter int TICK_DIV     = 100000,
  parameter int WAIT5_MS     = 5000,
  parameter int RWAIT_MIN_MS = 1000,
  parameter int RAND_BITS    = 11,
  parameter int LATE_MS      = 999
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rs_en,
  input  logic       start_rwait,
  input  logic       start_wait5,
  input  logic       time_clr,
  input  logic       time_en,
  output logic       rwait_done,
  output logic       wait5_done,
  output logic       time_late,
  output logic [9:0] rt_ms
);
  localparam int NUM_CH  = 2;
  localparam int RW_NEED = $clog2(RWAIT_MIN_MS + (1 << RAND_BITS));
  localparam int W5_NEED = $clog2(WAIT5_MS + 1);
  localparam int CW0     = (RW_NEED > 13) ? RW_NEED : 13;
  localparam int CW      = (W5_NEED > CW0) ? W5_NEED : CW0;
  localparam int PW      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] TMAX = PW'(TICK_DIV - 1);

  logic [15:0]                   lfsr;
  logic [PW-1:0]                 wp, rp;
  logic                          wtick, rtick;
  logic [NUM_CH-1:0]             req, rise, done;
  logic [NUM_CH-1:0][CW-1:0]     load_val;

  assign req         = {start_wait5, start_rwait};
  assign load_val[0] = CW'(RWAIT_MIN_MS) + CW'(lfsr[RAND_BITS-1:0]);
  assign load_val[1] = CW'(WAIT5_MS);
  assign rwait_done  = done[0];
  assign wait5_done  = done[1];

  assign wtick     = (wp == TMAX);
  assign rtick     = (rp == TMAX);
  assign time_late = (rt_ms >= 10'(LATE_MS));

  genvar g;
  generate
    for (g = 0; g < NUM_CH; g++) begin : g_ch
      reaction_timer_chan #(.CW(CW)) u_ch (
        .clk      (clk),
        .rst      (rst),
        .req      (req[g]),
        .wtick    (wtick),
        .load_val (load_val[g]),
        .rise     (rise[g]),
        .done     (done[g])
      );
    end
  endgenerate

  // Taps 16,14,13,11; the load above sees the pre-shift value on the same edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)       lfsr <= 16'hACE1;
    else if (rs_en) lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end

  // Any new wait restarts the ms phase so its first tick is a full ms away.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                wp <= '0;
    else if (|rise || wtick) wp <= '0;
    else                     wp <= wp + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                           rp <= '0;
    else if (time_clr || !time_en || rtick) rp <= '0;
    else                                rp <= rp + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                      rt_ms <= '0;
    else if (time_clr)                             rt_ms <= '0;
    else if (time_en && rtick && rt_ms != 10'h3FF) rt_ms <= rt_ms + 1'b1;
  end
endmodule

// File: tb/tb_reaction_timer_unit.sv
// Scoreboard bench for reaction_timer_unit: a cycle-level behavioural model
// pushes expected outputs, a monitor pops and compares each cycle.
module tb_reaction_timer_unit;
  localparam int T = 4, W5 = 5, RMIN = 3, RB = 2, LATE = 10;

  logic       clk = 1'b0, rst = 1'b0, rs_en = 1'b0;
  logic       start_rwait = 1'b0, start_wait5 = 1'b0, time_clr = 1'b0, time_en = 1'b0;
  logic       rwait_done, wait5_done, time_late;
  logic [9:0] rt_ms;

  reaction_timer_unit #(
    .TICK_DIV(T), .WAIT5_MS(W5), .RWAIT_MIN_MS(RMIN), .RAND_BITS(RB), .LATE_MS(LATE)
  ) dut (
    .clk(clk), .rst(rst), .rs_en(rs_en), .start_rwait(start_rwait),
    .start_wait5(start_wait5), .time_clr(time_clr), .time_en(time_en),
    .rwait_done(rwait_done), .wait5_done(wait5_done), .time_late(time_late), .rt_ms(rt_ms)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       rw;
    logic       w5;
    logic       late;
    logic [9:0] rt;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   errors = 0, checks = 0;

  // Behavioural model state: ms remaining per wait, cycles since the shared
  // phase restart, and length of the current uninterrupted counting run.
  logic [15:0] m_lfsr;
  bit          m_prev[2], m_armed[2];
  int          m_rem[2], m_phase, m_run, m_rt;

  task automatic model_reset();
    m_lfsr = 16'hACE1;
    for (int i = 0; i < 2; i++) begin
      m_prev[i] = 1'b1; m_armed[i] = 1'b0; m_rem[i] = 0;
    end
    m_phase = 0; m_run = 0; m_rt = 0;
  endtask

  task automatic model_edge();
    bit req[2], rise[2], tick;
    req[0] = start_rwait; req[1] = start_wait5;
    tick = (m_phase == T - 1);
    for (int i = 0; i < 2; i++) begin
      rise[i] = req[i] && !m_prev[i];
      if (rise[i]) begin
        m_rem[i]   = (i == 0) ? RMIN + int'(m_lfsr % (1 << RB)) : W5;
        m_armed[i] = 1'b1;
      end else begin
        if (!req[i]) m_armed[i] = 1'b0;
        if (req[i] && m_rem[i] > 0 && tick) m_rem[i]--;
      end
      m_prev[i] = req[i];
    end
    m_phase = (rise[0] || rise[1]) ? 0 : (m_phase + 1) % T;
    if (rs_en) m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    if (time_clr) begin
      m_run = 0; m_rt = 0;
    end else if (!time_en) begin
      m_run = 0;
    end else begin
      m_run++;
      if (m_run % T == 0 && m_rt < 1023) m_rt++;
    end
  endtask

  function automatic exp_t model_out();
    exp_t e;
    e.rw   = start_rwait && m_armed[0] && m_rem[0] == 0;
    e.w5   = start_wait5 && m_armed[1] && m_rem[1] == 0;
    e.late = (m_rt >= LATE);
    e.rt   = 10'(m_rt);
    return e;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Called from a negedge; inputs set before the call are sampled at the next edge.
  task automatic step();
    @(posedge clk);
    if (rst) model_edge(); else model_reset();
    #1 sb.push_back(model_out());
    @(negedge clk);
  endtask

  task automatic reset_mid();
    @(posedge clk);
    if (rst) model_edge(); else model_reset();
    #1 sb.push_back(model_out());
    #2 rst = 1'b0;
    #1;
    chk("rst_async_rwait_done", int'(rwait_done), 0);
    chk("rst_async_wait5_done", int'(wait5_done), 0);
    chk("rst_async_time_late", int'(time_late), 0);
    chk("rst_async_rt_ms", int'(rt_ms), 0);
    model_reset();
    @(negedge clk);
  endtask

  always @(posedge clk) begin
    #2;
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      chk("sb_rwait_done", int'(rwait_done), int'(mon_e.rw));
      chk("sb_wait5_done", int'(wait5_done), int'(mon_e.w5));
      chk("sb_time_late", int'(time_late), int'(mon_e.late));
      chk("sb_rt_ms", int'(rt_ms), int'(mon_e.rt));
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bit saw;
    model_reset();
    @(negedge clk);
    repeat (3) step();
    rst = 1'b1;
    step();

    // Random wait, LFSR untouched since reset: 4 ms -> 16 cycles.
    start_rwait = 1'b1; step();
    n = 0;
    do begin step(); n++; end while (!rwait_done && n < 100);
    chk("rwait_latency", n, 16);
    start_rwait = 1'b0; #1;
    chk("rwait_drop_same_cycle", int'(rwait_done), 0);
    repeat (3) step();

    // Early drop then full reload.
    start_rwait = 1'b1; saw = 1'b0;
    repeat (5) begin step(); saw |= rwait_done; end
    start_rwait = 1'b0;
    repeat (4) begin step(); saw |= rwait_done; end
    chk("early_drop_no_done", int'(saw), 0);
    start_rwait = 1'b1; step();
    n = 0;
    do begin step(); n++; end while (!rwait_done && n < 100);
    chk("rwait_rerise_latency", n, 16);
    start_rwait = 1'b0; step();

    // Fixed 5 ms wait.
    start_wait5 = 1'b1; step();
    n = 0;
    do begin step(); n++; end while (!wait5_done && n < 100);
    chk("wait5_latency", n, 20);
    repeat (5) step();
    chk("wait5_held", int'(wait5_done), 1);
    start_wait5 = 1'b0; #1;
    chk("wait5_drop_same_cycle", int'(wait5_done), 0);
    step();

    // Simultaneous rises.
    start_rwait = 1'b1; start_wait5 = 1'b1;
    repeat (25) step();
    start_rwait = 1'b0; start_wait5 = 1'b0;
    step();

    // Reaction count and late threshold.
    time_clr = 1'b1; step();
    time_clr = 1'b0; time_en = 1'b1;
    repeat (39) step();
    chk("rt_at_39", int'(rt_ms), 9);
    chk("late_at_39", int'(time_late), 0);
    step();
    chk("rt_at_40", int'(rt_ms), 10);
    chk("late_at_40", int'(time_late), 1);
    time_clr = 1'b1; step();
    time_clr = 1'b0;
    repeat (28) step();
    time_en = 1'b0;
    repeat (10) step();
    chk("rt_hold_7", int'(rt_ms), 7);
    chk("late_hold_7", int'(time_late), 0);

    // Clear beats enable.
    time_clr = 1'b1; time_en = 1'b1;
    repeat (12) step();
    chk("clr_prio_rt", int'(rt_ms), 0);
    chk("clr_prio_late", int'(time_late), 0);
    time_clr = 1'b0;

    // Mid-operation reset with start_wait5 held.
    repeat (20) step();
    start_wait5 = 1'b1;
    repeat (22) step();
    chk("pre_reset_wait5_done", int'(wait5_done), 1);
    reset_mid();
    repeat (2) step();
    rst = 1'b1; time_en = 1'b0; saw = 1'b0;
    repeat (30) begin step(); saw |= wait5_done; end
    chk("no_rearm_after_reset", int'(saw), 0);
    start_wait5 = 1'b0; step();
    start_wait5 = 1'b1; step();
    n = 0;
    do begin step(); n++; end while (!wait5_done && n < 100);
    chk("wait5_after_reset_latency", n, 20);
    start_wait5 = 1'b0; step();

    // Randomised traffic.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 15) == 0) start_rwait = ~start_rwait;
      if ($urandom_range(0, 15) == 0) start_wait5 = ~start_wait5;
      if ($urandom_range(0, 39) == 0) time_en = ~time_en;
      rs_en    = 1'($urandom_range(0, 1));
      time_clr = ($urandom_range(0, 63) == 0);
      step();
    end
    start_rwait = 1'b0; start_wait5 = 1'b0; time_clr = 1'b0; rs_en = 1'b0;

    // Saturation.
    time_clr = 1'b1; step();
    time_clr = 1'b0; time_en = 1'b1;
    repeat (4200) step();
    chk("rt_saturate", int'(rt_ms), 1023);
    chk("late_saturate", int'(time_late), 1);
    time_en = 1'b0;
    repeat (3) step();
    chk("sb_drained", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
